// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg
// Shared definitions for the pipeline hazard controller:
//   state_t  - FSM state encoding (RUN/STALL/HALT)
//   FWD_*    - ALU operand forwarding select codes
//   PC_SEQ   - pc_src value meaning "sequential fetch, no redirect"
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] PC_SEQ  = 2'b00;

endpackage

// File: rtl/hazard_controller_fwd_select.sv
// fwd_select
// Combinational forwarding priority mux for one ALU operand.
// Ports:
//   i_src            - register address read by the instruction in IF/ID
//   i_mem_rd         - destination held in EX/MEM
//   i_mem_reg_write  - EX/MEM writes the register file
//   i_mem_mem_or_alu - EX/MEM result comes from the ALU (0 = load)
//   i_wb_rd          - destination held in MEM/WB
//   i_wb_reg_write   - MEM/WB writes the register file
//   o_sel            - FWD_MEM / FWD_WB / FWD_RF
module fwd_select
  import hazard_controller_pkg::*;
(
  input  logic [2:0] i_src,
  input  logic [2:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic       i_mem_mem_or_alu,
  input  logic [2:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_sel
);

  // EX/MEM is the younger producer so it wins; a load in EX/MEM has no data yet.
  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_reg_write && i_mem_mem_or_alu && (i_mem_rd == i_src)) begin
      o_sel = FWD_MEM;
    end else if (i_wb_reg_write && (i_wb_rd == i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
// Stall/flush/forwarding control for the 5-stage pipeline.
// Ports:
//   i_clk, i_rst                      - clock, async active-high reset
//   i_id_*                            - operand addresses/uses of the IF/ID instruction
//   i_ex_*, i_mem_*, i_wb_*           - destination/WB controls of ID/EX, EX/MEM, MEM/WB
//   i_mem_pc_src                      - non-zero = redirect resolved in EX/MEM
//   i_stack_overflow                  - forces a sticky halt
//   o_pc_write, o_ifid_write          - advance enables
//   o_ifid_flush, o_idex_bubble, o_exmem_flush - squash controls
//   o_fwd_a, o_fwd_b                  - operand forwarding selects
//   o_halted                          - sticky halt flag
//   o_stall_count, o_flush_count      - saturating statistics
//
// state | meaning
// RUN   | normal issue, load-use detection active
// STALL | one cycle after a load-use bubble, detection suppressed
// HALT  | stack overflow seen, pipeline frozen until reset
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_id_rs1,
  input  logic [2:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [2:0]       i_ex_rd,
  input  logic             i_ex_reg_write,
  input  logic             i_ex_mem_or_alu,
  input  logic [2:0]       i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic             i_mem_mem_or_alu,
  input  logic [2:0]       i_wb_rd,
  input  logic             i_wb_reg_write,
  input  logic [1:0]       i_mem_pc_src,
  input  logic             i_stack_overflow,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_exmem_flush,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  state_t           r_state;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_redirect;
  logic             w_load_use;

  assign w_redirect = (i_mem_pc_src != PC_SEQ);
  assign w_load_use = i_ex_reg_write && !i_ex_mem_or_alu &&
                      ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

  fwd_select u_fwd_a (
    .i_src            (i_id_rs1),
    .i_mem_rd         (i_mem_rd),
    .i_mem_reg_write  (i_mem_reg_write),
    .i_mem_mem_or_alu (i_mem_mem_or_alu),
    .i_wb_rd          (i_wb_rd),
    .i_wb_reg_write   (i_wb_reg_write),
    .o_sel            (o_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_src            (i_id_rs2),
    .i_mem_rd         (i_mem_rd),
    .i_mem_reg_write  (i_mem_reg_write),
    .i_mem_mem_or_alu (i_mem_mem_or_alu),
    .i_wb_rd          (i_wb_rd),
    .i_wb_reg_write   (i_wb_reg_write),
    .o_sel            (o_fwd_b)
  );

  // Outputs react in the same cycle, so they are decoded from state + inputs.
  always_comb begin
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_exmem_flush = 1'b0;
    case (r_state)
      ST_HALT: begin
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b1;
      end
      default: begin
        if (w_redirect) begin
          o_ifid_flush  = 1'b1;
          o_idex_bubble = 1'b1;
          o_exmem_flush = 1'b1;
        end else if ((r_state == ST_RUN) && w_load_use) begin
          o_pc_write    = 1'b0;
          o_ifid_write  = 1'b0;
          o_idex_bubble = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_halted      <= 1'b0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      case (r_state)
        ST_HALT: r_state <= ST_HALT;
        default: begin
          if (w_redirect) begin
            r_state <= ST_RUN;
            if (r_flush_count != '1) r_flush_count <= r_flush_count + CNT_W'(1);
          end else if ((r_state == ST_RUN) && w_load_use) begin
            r_state <= ST_STALL;
            if (r_stall_count != '1) r_stall_count <= r_stall_count + CNT_W'(1);
          end else begin
            r_state <= ST_RUN;
          end
        end
      endcase
      // Overflow overrides whatever transition was chosen above.
      if (i_stack_overflow) begin
        r_state  <= ST_HALT;
        r_halted <= 1'b1;
      end
    end
  end

  assign o_halted      = r_halted;
  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [2:0]       id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2;
  logic [2:0]       ex_rd;
  logic             ex_reg_write, ex_mem_or_alu;
  logic [2:0]       mem_rd;
  logic             mem_reg_write, mem_mem_or_alu;
  logic [2:0]       wb_rd;
  logic             wb_reg_write;
  logic [1:0]       mem_pc_src;
  logic             stack_overflow;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_vec;
  int n_err;

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_id_use_rs1     (id_use_rs1),
    .i_id_use_rs2     (id_use_rs2),
    .i_ex_rd          (ex_rd),
    .i_ex_reg_write   (ex_reg_write),
    .i_ex_mem_or_alu  (ex_mem_or_alu),
    .i_mem_rd         (mem_rd),
    .i_mem_reg_write  (mem_reg_write),
    .i_mem_mem_or_alu (mem_mem_or_alu),
    .i_wb_rd          (wb_rd),
    .i_wb_reg_write   (wb_reg_write),
    .i_mem_pc_src     (mem_pc_src),
    .i_stack_overflow (stack_overflow),
    .o_pc_write       (pc_write),
    .o_ifid_write     (ifid_write),
    .o_ifid_flush     (ifid_flush),
    .o_idex_bubble    (idex_bubble),
    .o_exmem_flush    (exmem_flush),
    .o_fwd_a          (fwd_a),
    .o_fwd_b          (fwd_b),
    .o_halted         (halted),
    .o_stall_count    (stall_count),
    .o_flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}
  localparam logic [4:0] CTL_NORMAL   = 5'b11000;
  localparam logic [4:0] CTL_STALL    = 5'b00010;
  localparam logic [4:0] CTL_REDIRECT = 5'b11111;
  localparam logic [4:0] CTL_HALT     = 5'b00010;

  logic [4:0] ctl;
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush};

  task automatic quiet();
    id_rs1 = 3'd0; id_rs2 = 3'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 3'd0; ex_reg_write = 1'b0; ex_mem_or_alu = 1'b1;
    mem_rd = 3'd0; mem_reg_write = 1'b0; mem_mem_or_alu = 1'b1;
    wb_rd = 3'd0; wb_reg_write = 1'b0;
    mem_pc_src = 2'b00; stack_overflow = 1'b0;
  endtask

  task automatic set_load_use_rs1();
    ex_rd = 3'd3; ex_reg_write = 1'b1; ex_mem_or_alu = 1'b0;
    id_rs1 = 3'd3; id_use_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (ctl !== CTL_NORMAL) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_NORMAL); end
    n_vec++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b}); end
    n_vec++;
    if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_vec++;
    if ({stall_count, flush_count} !== '0) begin n_err++; $display("FAIL reset_counts: got %h/%h want 0/0", stall_count, flush_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    // rs1 hazard: one stall cycle, then STALL suppresses the still-present hazard
    set_load_use_rs1();
    #1;
    n_vec++;
    if (ctl !== CTL_STALL) begin n_err++; $display("FAIL lu_rs1_stall: got %b want %b", ctl, CTL_STALL); end
    @(negedge clk); #1;
    n_vec++;
    if (ctl !== CTL_NORMAL) begin n_err++; $display("FAIL lu_stall_state: got %b want %b", ctl, CTL_NORMAL); end
    n_vec++;
    if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_stall_count1: got %0d want 1", stall_count); end
    quiet();
    @(negedge clk); #1;
    // non-load producer: no hazard
    set_load_use_rs1(); ex_mem_or_alu = 1'b1; #1;
    n_vec++;
    if (ctl !== CTL_NORMAL) begin n_err++; $display("FAIL lu_alu_producer: got %b want %b", ctl, CTL_NORMAL); end
    // matching address but operand not used: no hazard
    ex_mem_or_alu = 1'b0; id_use_rs1 = 1'b0; #1;
    n_vec++;
    if (ctl !== CTL_NORMAL) begin n_err++; $display("FAIL lu_unused_operand: got %b want %b", ctl, CTL_NORMAL); end
    // rs2 hazard
    id_rs1 = 3'd1; id_rs2 = 3'd3; id_use_rs2 = 1'b1; #1;
    n_vec++;
    if (ctl !== CTL_STALL) begin n_err++; $display("FAIL lu_rs2_stall: got %b want %b", ctl, CTL_STALL); end
    @(negedge clk);
    quiet();
    @(negedge clk); #1;
    n_vec++;
    if (stall_count !== 16'd2) begin n_err++; $display("FAIL lu_stall_count2: got %0d want 2", stall_count); end
  endtask

  task automatic test_redirect_priority();
    set_load_use_rs1();
    mem_pc_src = 2'b11; #1;
    n_vec++;
    if (ctl !== CTL_REDIRECT) begin n_err++; $display("FAIL redir_prio_ctl: got %b want %b", ctl, CTL_REDIRECT); end
    @(negedge clk);
    quiet(); #1;
    n_vec++;
    if (flush_count !== 16'd1) begin n_err++; $display("FAIL redir_flush_count: got %0d want 1", flush_count); end
    n_vec++;
    if (stall_count !== 16'd2) begin n_err++; $display("FAIL redir_stall_unchanged: got %0d want 2", stall_count); end
    n_vec++;
    if (ctl !== CTL_NORMAL) begin n_err++; $display("FAIL redir_after_ctl: got %b want %b", ctl, CTL_NORMAL); end
  endtask

  task automatic test_stall_redirect();
    set_load_use_rs1();
    @(negedge clk);
    quiet();
    mem_pc_src = 2'b10; #1;
    n_vec++;
    if (ctl !== CTL_REDIRECT) begin n_err++; $display("FAIL stall_redir_ctl: got %b want %b", ctl, CTL_REDIRECT); end
    @(negedge clk);
    quiet();
    // back in RUN: a fresh load-use must stall again (STALL would suppress it)
    set_load_use_rs1(); #1;
    n_vec++;
    if (ctl !== CTL_STALL) begin n_err++; $display("FAIL stall_redir_run: got %b want %b", ctl, CTL_STALL); end
    n_vec++;
    if ({stall_count, flush_count} !== {16'd3, 16'd2}) begin n_err++; $display("FAIL stall_redir_counts: got %0d/%0d want 3/2", stall_count, flush_count); end
    @(negedge clk);
    quiet();
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    quiet();
    mem_rd = 3'd5; wb_rd = 3'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    mem_mem_or_alu = 1'b1; id_rs2 = 3'd5; id_rs1 = 3'd2; #1;
    n_vec++;
    if ({fwd_a, fwd_b} !== 4'b0010) begin n_err++; $display("FAIL fwd_b_mem: got %b want 0010", {fwd_a, fwd_b}); end
    mem_mem_or_alu = 1'b0; #1;
    n_vec++;
    if (fwd_b !== 2'b01) begin n_err++; $display("FAIL fwd_b_wb_load: got %b want 01", fwd_b); end
    wb_reg_write = 1'b0; #1;
    n_vec++;
    if (fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_b_rf: got %b want 00", fwd_b); end
    // register 0 forwards like any other
    mem_rd = 3'd0; mem_mem_or_alu = 1'b1; id_rs1 = 3'd0; #1;
    n_vec++;
    if (fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_a_r0: got %b want 10", fwd_a); end
    mem_rd = 3'd7; mem_reg_write = 1'b0; wb_rd = 3'd7; wb_reg_write = 1'b1;
    id_rs1 = 3'd7; id_rs2 = 3'd7; #1;
    n_vec++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin n_err++; $display("FAIL fwd_ab_wb: got %b want 0101", {fwd_a, fwd_b}); end
    quiet();
    @(negedge clk);
  endtask

  task automatic test_halt();
    stack_overflow = 1'b1;
    @(negedge clk);
    stack_overflow = 1'b0;
    mem_pc_src = 2'b01;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_vec++;
      if ({halted, ctl} !== {1'b1, CTL_HALT}) begin n_err++; $display("FAIL halt_hold[%0d]: got %b want %b", i, {halted, ctl}, {1'b1, CTL_HALT}); end
      @(negedge clk);
    end
    n_vec++;
    if (flush_count !== 16'd2) begin n_err++; $display("FAIL halt_no_count: got %0d want 2", flush_count); end
    quiet();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({halted, ctl} !== {1'b0, CTL_NORMAL}) begin n_err++; $display("FAIL halt_async_rst: got %b want %b", {halted, ctl}, {1'b0, CTL_NORMAL}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    mem_pc_src = 2'b01;
    repeat (65534) @(negedge clk);
    #1;
    n_vec++;
    if (flush_count !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre: got %h want FFFE", flush_count); end
    repeat (10) @(negedge clk);
    #1;
    n_vec++;
    if (flush_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want FFFF", flush_count); end
    n_vec++;
    if (stall_count !== 16'd0) begin n_err++; $display("FAIL sat_stall_zero: got %h want 0", stall_count); end
    quiet();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    quiet();
    test_reset();
    test_load_use();
    test_redirect_priority();
    test_stall_redirect();
    test_forwarding();
    test_halt();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage, 8-bit/19-bit-instruction pipelined processor. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. It decides every cycle:

- whether the PC and IF/ID advance,
- which pipeline registers are squashed,
- where each ALU operand is forwarded from.

It also latches a sticky halt on stack overflow and keeps saturating stall/flush statistics.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush statistic counters

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs1  in  3  register-file read address 1 of the IF/ID instruction (bits 10:8)
- id_rs2  in  3  register-file read address 2 of the IF/ID instruction, after the reg2_read_source mux
- id_use_rs1, id_use_rs2  in  1 each  the IF/ID instruction actually reads that operand
- ex_rd  in  3  destination register held in ID/EX
- ex_reg_write, ex_mem_or_alu  in  1 each  ID/EX WB controls; mem_or_alu=0 means the result comes from data memory (load)
- mem_rd, mem_reg_write, mem_mem_or_alu  in  3/1/1  same fields held in EX/MEM
- wb_rd, wb_reg_write  in  3/1  same fields held in MEM/WB
- mem_pc_src  in  2  pc_src held in EX/MEM; any non-zero value is a redirect (jump, return, branch)
- stack_overflow  in  1  from the return stack
- pc_write, ifid_write  out  1 each  enables for the PC and IF/ID registers
- ifid_flush, idex_bubble, exmem_flush  out  1 each  zero the control fields of the corresponding register on this edge
- fwd_a, fwd_b  out  2 each  operand source: 00 register file, 01 MEM/WB, 10 EX/MEM
- halted  out  1  sticky halt indication
- stall_count, flush_count  out  CNT_W each  statistics

## Operation
- FSM states: RUN, STALL, HALT; encoded 2'b00, 2'b01, 2'b10.
- **Load-use hazard (RUN only):**
  - Condition: ex_reg_write && !ex_mem_or_alu && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Response: pc_write=0, ifid_write=0, idex_bubble=1, stall_count++.
  - Next state: STALL.
- **STALL:** exactly one cycle with all enables normal; then unconditionally back to RUN. A second load-use check is suppressed in STALL.
- **Redirect** (mem_pc_src!=0, any non-HALT state):
  - Response: ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1, flush_count++.
  - Next state: RUN.
  - Priority: the redirect beats a simultaneous load-use hazard, and that hazard is not counted.
- **Stack overflow** (any state, including simultaneous with a redirect or hazard):
  - Next state: HALT.
  - HALT outputs: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, exmem_flush=0, halted=1.
  - HALT is left only by rst.
- **Forwarding** (combinational, all states, independent for operands A and B):
  - Select 10 if mem_reg_write && mem_mem_or_alu && mem_rd==src.
  - Else select 01 if wb_reg_write && wb_rd==src.
  - Else select 00.
  - All 8 registers participate; there is no hard-wired zero register.
  - A load in EX/MEM is never forwarded from EX/MEM.
- **Counters:** increment by 1 per qualifying cycle and saturate at all-ones. They are not cleared except by rst.

## Timing
- All stall, flush and forwarding outputs are combinational from the current inputs and state, valid within the same cycle. There is no added latency.
- The state register and counters update on the rising edge of clk.
- A load-use hazard costs exactly 1 bubble. A redirect squashes exactly the 3 younger instructions on the same edge that the PC loads its target.
- Reset values (asynchronous, active-high):
  - state=RUN, halted=0, stall_count=0, flush_count=0.
  - pc_write=1, ifid_write=1, and all flush/bubble outputs=0 while stable inputs are quiet.
  - fwd_a=fwd_b=00.
- Reset asserted mid-STALL or in HALT returns to RUN immediately, without waiting for a clock edge.

## Structure
- Shared package holds:
  - the FSM state encoding,
  - the forwarding select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10,
  - the pc_src constant PC_SEQ=00.
- One sub-module, fwd_select: combinational priority mux for one operand (src, mem fields, wb fields -> 2-bit select). Instantiate it twice, for A and B.
- The FSM and counters live in hazard_controller itself.

## Test plan
- ex_rd=3, ex_reg_write=1, ex_mem_or_alu=0, id_rs1=3, id_use_rs1=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle all enables normal; stall_count=1.
- mem_pc_src=2'b11 while the load-use condition also holds -> ifid_flush=idex_bubble=exmem_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
- mem_rd=wb_rd=5, both reg_write=1, mem_mem_or_alu=1, id_rs2=5 -> fwd_b=10; then mem_mem_or_alu=0 -> fwd_b=01; then wb_reg_write=0 -> fwd_b=00.
- stack_overflow pulsed for 1 cycle -> halted=1 and pc_write=0 held for 20 cycles; assert rst asynchronously -> halted=0 before the next edge.
- Force 70000 consecutive redirects with CNT_W=16 -> flush_count saturates at 16'hFFFF, no wrap.
- Redirect with mem_pc_src=2'b10 during the STALL cycle -> flush outputs asserted; state=RUN afterwards.
